// File: rtl/program_loader_if.sv
// Signal bundle between the host side (upstream byte stream, control-block strobes)
// and program_loader. The master modport drives requests; the slave is the loader.
interface program_loader_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [4:0]        load_len;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ready;
  logic              read_ui_in;
  logic              done_load;
  logic              hf;
  logic              programming;
  logic [DATA_W-1:0] prog_data;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, load_len, in_data, in_valid, ready, read_ui_in, done_load, hf,
    input  in_ready, programming, prog_data, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, load_len, in_data, in_valid, ready, read_ui_in, done_load, hf,
    output in_ready, programming, prog_data, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/program_loader.sv
// Collects a program image into a local buffer and replays it into the CPU via the
// programming handshake. Optional watchdog: define PROG_LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int RST_CYC     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RST_CYC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_RST_A   = 3'd2,
    S_SYNC    = 3'd3,
    S_STREAM  = 3'd4,
    S_RST_B   = 3'd5
  } state_t;

  state_t              r_state, w_state;
  logic [IDX_W-1:0]    r_last, w_last;
  logic [IDX_W-1:0]    r_wr_idx, w_wr_idx;
  logic [IDX_W-1:0]    r_rd_idx, w_rd_idx;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_in_ready, w_in_ready;
  logic                r_programming, w_programming;
  logic [DATA_W-1:0]   r_prog_data, w_prog_data;
  logic                r_cpu_rst, w_cpu_rst;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_err, w_err;
  logic                r_seen_ready, w_seen_ready;
  logic                r_hf_q;
  logic                w_buf_we;
  logic                w_viol;
  logic                w_abort;
  logic                w_hf_rise;
  logic                w_wd_expire;
  logic [IDX_W-1:0]    w_len_last;
  logic [DATA_W-1:0]   r_buf [DEPTH];

  assign w_hf_rise  = bus.hf && !r_hf_q;
  assign w_len_last = (bus.load_len > 5'(DEPTH)) ? IDX_W'(DEPTH - 1)
                                                 : IDX_W'(bus.load_len - 5'd1);

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] r_wdog, w_wdog;
  logic            w_wd_watch;

  assign w_wd_watch  = (r_state == S_COLLECT) || (r_state == S_SYNC) || (r_state == S_STREAM);
  assign w_wd_expire = w_wd_watch && !bus.ready && !bus.done_load &&
                       (r_wdog == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog restarts on any state change or control-block strobe.
  always_comb begin
    w_wdog = {WD_W{1'b0}};
    if (w_wd_watch && !bus.ready && !bus.done_load && (w_state == r_state)) begin
      w_wdog = r_wdog + WD_W'(1);
    end else begin
      w_wdog = {WD_W{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= {WD_W{1'b0}};
    end else begin
      r_wdog <= w_wdog;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
  assign w_wd_expire      = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state       = r_state;
    w_last        = r_last;
    w_wr_idx      = r_wr_idx;
    w_rd_idx      = r_rd_idx;
    w_cnt         = r_cnt;
    w_in_ready    = r_in_ready;
    w_programming = r_programming;
    w_prog_data   = r_prog_data;
    w_cpu_rst     = r_cpu_rst;
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_err         = r_err;
    w_seen_ready  = r_seen_ready;
    w_buf_we      = 1'b0;
    w_viol        = 1'b0;
    w_abort       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.load_len == 5'd0)) begin
          w_done = 1'b1;
        end else if (bus.start) begin
          w_state    = S_COLLECT;
          w_last     = w_len_last;
          w_wr_idx   = {IDX_W{1'b0}};
          w_err      = 1'b0;
          w_in_ready = 1'b1;
          w_busy     = 1'b1;
        end else begin
          w_done = 1'b0;
        end
      end
      S_COLLECT: begin
        if (bus.in_valid && r_in_ready) begin
          w_buf_we = 1'b1;
          if (r_wr_idx == r_last) begin
            w_state       = S_RST_A;
            w_in_ready    = 1'b0;
            w_cpu_rst     = 1'b1;
            w_programming = 1'b1;
            w_cnt         = {CNT_W{1'b0}};
            w_rd_idx      = {IDX_W{1'b0}};
          end else begin
            w_wr_idx = r_wr_idx + IDX_W'(1);
          end
        end else begin
          w_buf_we = 1'b0;
        end
      end
      S_RST_A: begin
        w_prog_data = r_buf[r_rd_idx];
        if (r_cnt == CNT_W'(RST_CYC - 1)) begin
          w_state   = S_SYNC;
          w_cpu_rst = 1'b0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_SYNC: begin
        // Strobes before the first ready are stray and ignored.
        if (bus.ready && bus.done_load) begin
          w_viol = 1'b1;
        end else if (bus.ready) begin
          w_state      = S_STREAM;
          w_seen_ready = 1'b1;
        end else begin
          w_seen_ready = 1'b0;
        end
      end
      S_STREAM: begin
        if (bus.ready && bus.done_load) begin
          w_viol = 1'b1;
        end else if (bus.read_ui_in && !(r_seen_ready || bus.ready)) begin
          w_viol = 1'b1;
        end else if (bus.done_load) begin
          w_seen_ready = 1'b0;
          if (r_rd_idx == r_last) begin
            w_state       = S_RST_B;
            w_programming = 1'b0;
            w_cpu_rst     = 1'b1;
            w_cnt         = {CNT_W{1'b0}};
          end else begin
            w_rd_idx    = r_rd_idx + IDX_W'(1);
            w_prog_data = r_buf[r_rd_idx + IDX_W'(1)];
          end
        end else if (bus.ready) begin
          w_seen_ready = 1'b1;
        end else begin
          w_seen_ready = r_seen_ready;
        end
      end
      S_RST_B: begin
        if (r_cnt == CNT_W'(RST_CYC - 1)) begin
          w_state     = S_IDLE;
          w_cpu_rst   = 1'b0;
          w_busy      = 1'b0;
          w_done      = !r_err;
          w_prog_data = {DATA_W{1'b0}};
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state       = S_IDLE;
        w_in_ready    = 1'b0;
        w_programming = 1'b0;
        w_cpu_rst     = 1'b0;
        w_busy        = 1'b0;
      end
    endcase

    w_abort = w_viol || w_wd_expire ||
              (((r_state == S_SYNC) || (r_state == S_STREAM)) && w_hf_rise);
    // Abort still resets the CPU so it never runs a half-loaded image.
    if (w_abort) begin
      w_state       = S_RST_B;
      w_err         = 1'b1;
      w_programming = 1'b0;
      w_cpu_rst     = 1'b1;
      w_in_ready    = 1'b0;
      w_busy        = 1'b1;
      w_done        = 1'b0;
      w_buf_we      = 1'b0;
      w_cnt         = {CNT_W{1'b0}};
    end else begin
      w_err = w_err;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last        <= {IDX_W{1'b0}};
      r_wr_idx      <= {IDX_W{1'b0}};
      r_rd_idx      <= {IDX_W{1'b0}};
      r_cnt         <= {CNT_W{1'b0}};
      r_in_ready    <= 1'b0;
      r_programming <= 1'b0;
      r_prog_data   <= {DATA_W{1'b0}};
      r_cpu_rst     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_seen_ready  <= 1'b0;
      r_hf_q        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_last        <= w_last;
      r_wr_idx      <= w_wr_idx;
      r_rd_idx      <= w_rd_idx;
      r_cnt         <= w_cnt;
      r_in_ready    <= w_in_ready;
      r_programming <= w_programming;
      r_prog_data   <= w_prog_data;
      r_cpu_rst     <= w_cpu_rst;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_err         <= w_err;
      r_seen_ready  <= w_seen_ready;
      r_hf_q        <= bus.hf;
    end
  end

  // Image buffer; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_wr_idx] <= bus.in_data;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.programming = r_programming;
  assign bus.prog_data   = r_prog_data;
  assign bus.cpu_rst     = r_cpu_rst;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader: an image/rule model in the bench predicts
// accepted bytes, replayed bytes, reset-pulse lengths and completion flags.
module tb_program_loader;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int RST_CYC = 4;
  localparam int TMO     = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.DATA_W(DATA_W)) bus();

  program_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RST_CYC(RST_CYC), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] img [16];
  logic [7:0] acc_q [$];
  logic [7:0] rd_log [$];
  int rd_k = 0;
  int run_len = 0;
  int run_no = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mid-cycle compare process against the image/rule model.
  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) acc_q.push_back(bus.in_data);
    if (bus.read_ui_in && bus.programming) begin
      rd_log.push_back(bus.prog_data);
      if (rd_k < DEPTH) check("prog_data", 32'(bus.prog_data), 32'(img[rd_k]));
    end
    if (bus.done_load) rd_k++;
    if (bus.cpu_rst) begin
      run_len++;
      if (run_len == 1) run_no++;
      check("prog_in_rst", 32'(bus.programming), 32'(run_no == 1));
    end else if (run_len != 0) begin
      check("cpu_rst_len", 32'(run_len), 32'(RST_CYC));
      run_len = 0;
    end
    check("done_single", 32'(prev_done && bus.done), 32'd0);
    if (bus.done) done_cnt++;
    prev_done = bus.done;
    if (!bus.busy) check("idle_outs", 32'({bus.in_ready, bus.programming, bus.cpu_rst}), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cond(input string nm, input int sel);
    bit ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      case (sel)
        0: ok = bus.in_ready;
        1: ok = bus.programming && !bus.cpu_rst;
        2: ok = !bus.busy;
        default: ok = 1'b1;
      endcase
    end
    check({"wait_", nm}, 32'(ok), 32'd1);
  endtask

  task automatic start_load(input int len);
    acc_q.delete();
    rd_log.delete();
    rd_k = 0;
    run_no = 0;
    done_cnt = 0;
    bus.start = 1'b1;
    bus.load_len = 5'(len);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input bit stall, input bit mid_start);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_data = img[i];
      bus.in_valid = 1'b1;
      if (mid_start && i == 1) begin
        bus.start = 1'b1;
        bus.load_len = 5'($urandom_range(1, 20));
      end
      wait_cond("in_ready", 0);
      tick();
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic cb_instr(input bit do_ready, input int gap);
    if (do_ready) begin
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
    end
    repeat (2) tick();
    bus.read_ui_in = 1'b1;
    tick();
    bus.read_ui_in = 1'b0;
    bus.done_load = 1'b1;
    tick();
    bus.done_load = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic run_load(input int len, input bit stall, input bit mid_start,
                          input int hf_at, input bit viol);
    int n;
    bit aborted;
    n = (len > DEPTH) ? DEPTH : len;
    aborted = 1'b0;
    start_load(len);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_err_clr", 32'(bus.err), 32'd0);
    send_bytes(n, stall, mid_start);
    if (len > DEPTH) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      repeat (4) tick();
      check("in_ready_after", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
    end
    check("acc_cnt", 32'(acc_q.size()), 32'(n));
    for (int i = 0; i < n && i < acc_q.size(); i++) check("acc_data", 32'(acc_q[i]), 32'(img[i]));
    wait_cond("sync", 1);
    tick();
    for (int k = 0; k < n; k++) begin
      if (viol && k == 1) begin
        cb_instr(1'b0, 2);
        aborted = 1'b1;
        break;
      end
      cb_instr(1'b1, $urandom_range(0, 3));
      if (hf_at == k + 1) begin
        bus.hf = 1'b1;
        tick();
        tick();
        bus.hf = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    wait_cond("idle", 2);
    tick();
    tick();
    check("done_cnt", 32'(done_cnt), aborted ? 32'd0 : 32'd1);
    check("err", 32'(bus.err), 32'(aborted));
    check("rst_runs", 32'(run_no), 32'd2);
    if (!aborted) check("reads", 32'(rd_log.size()), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.load_len = 5'd0; bus.in_data = 8'd0; bus.in_valid = 1'b0;
    bus.ready = 1'b0; bus.read_ui_in = 1'b0; bus.done_load = 1'b0; bus.hf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'({bus.in_ready, bus.programming, bus.prog_data, bus.cpu_rst,
                             bus.busy, bus.done, bus.err}), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Zero-length load: done next cycle, stays idle.
    start_load(0);
    check("len0_done", 32'(bus.done), 32'd1);
    check("len0_busy", 32'(bus.busy), 32'd0);
    tick();
    check("len0_done_off", 32'(bus.done), 32'd0);

    // Nominal 3-byte image with literal expectations.
    img[0] = 8'h4E; img[1] = 8'h5F; img[2] = 8'h00;
    run_load(3, 1'b0, 1'b0, 0, 1'b0);
    check("nom_b0", 32'(rd_log[0]), 32'h4E);
    check("nom_b1", 32'(rd_log[1]), 32'h5F);
    check("nom_b2", 32'(rd_log[2]), 32'h00);

    // Stalling upstream, full depth; then oversize length.
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    run_load(16, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    run_load(20, 1'b0, 1'b0, 0, 1'b0);

    // Halt abort after the 2nd byte, then a protocol violation abort.
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    run_load(5, 1'b0, 1'b0, 2, 1'b0);
    run_load(3, 1'b0, 1'b0, 0, 1'b1);

    // Async reset between read_ui_in and done_load of byte 1.
    for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    start_load(3);
    send_bytes(3, 1'b0, 1'b0);
    wait_cond("sync_r", 1);
    tick();
    cb_instr(1'b1, 0);
    bus.ready = 1'b1; tick(); bus.ready = 1'b0;
    tick(); tick();
    bus.read_ui_in = 1'b1; tick(); bus.read_ui_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_outs", 32'({bus.in_ready, bus.programming, bus.prog_data, bus.cpu_rst,
                                 bus.busy, bus.done, bus.err}), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_load(2, 1'b0, 1'b0, 0, 1'b0);

    // Control block stops issuing ready mid-stream.
    start_load(2);
    send_bytes(2, 1'b0, 1'b0);
    wait_cond("sync_t", 1);
    tick();
    cb_instr(1'b1, 0);
`ifdef PROG_LOADER_TIMEOUT_EN
    repeat (TMO - 1) tick();
    check("tmo_early", 32'(bus.err), 32'd0);
    tick();
    check("tmo_err", 32'(bus.err), 32'd1);
`else
    repeat (200) tick();
    check("stuck_busy", 32'(bus.busy), 32'd1);
    check("stuck_err", 32'(bus.err), 32'd0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Randomised loads, some with a start pulse while busy.
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
      run_load(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
